// File: rtl/shift_74hc595_chain.sv
// Serialises a CHIPS*8-bit frame onto a daisy-chain of 74HC595s (DS / SH_CP / ST_CP).
// Latency: 1 load cycle, then 2W+2 wr_en ticks per frame; done pulses the cycle after the final tick.
// Backpressure: one-deep holding buffer (ready = empty); rd_en into a full buffer overwrites it and pulses overrun.
//
// Ports:
//   clk, rst_n      - system clock, synchronous active-low reset
//   rd_en, data_in  - capture strobe and frame to display
//   wr_en           - bit-rate clock-enable tick from the divider
//   ready, busy     - holding buffer empty / frame being serialised
//   done, overrun   - one-cycle status pulses (frame latched / buffered frame overwritten)
//   data_out, register_clock, latch - DS, SH_CP, ST_CP pins
module shift_74hc595_chain #(
   parameter int CHIPS     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rd_en,
   input  logic [8*CHIPS-1:0]   data_in,
   input  logic                 wr_en,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   output logic                 data_out,
   output logic                 register_clock,
   output logic                 latch
);

   localparam int W  = 8 * CHIPS;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_CLK_HI,
      S_LATCH_HI,
      S_LATCH_LO
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    sr, sr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [W-1:0]    hold_dat, hold_dat_nxt;
   logic            hold_vld, hold_vld_nxt;
   logic            data_out_nxt, register_clock_nxt, latch_nxt;
   logic            done_nxt, overrun_nxt;
   logic            consume;

   // The IDLE state drains the buffer without waiting for a tick.
   assign consume = (state == S_IDLE) && hold_vld;

   always_comb begin
      state_nxt          = state;
      sr_nxt             = sr;
      cnt_nxt            = cnt;
      hold_dat_nxt       = hold_dat;
      hold_vld_nxt       = hold_vld;
      data_out_nxt       = data_out;
      register_clock_nxt = register_clock;
      latch_nxt          = latch;
      done_nxt           = 1'b0;
      overrun_nxt        = 1'b0;

      // A write landing on the consume cycle refills the buffer; it is not an overrun
      // because the previous frame has just been moved into the shift register.
      if (rd_en) begin
         hold_dat_nxt = data_in;
         hold_vld_nxt = 1'b1;
         overrun_nxt  = hold_vld && !consume;
      end else if (consume) begin
         hold_vld_nxt = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (hold_vld) begin
               sr_nxt    = hold_dat;
               cnt_nxt   = CW'(W - 1);
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (wr_en) begin
               data_out_nxt       = MSB_FIRST ? sr[W-1] : sr[0];
               register_clock_nxt = 1'b0;
               state_nxt          = S_CLK_HI;
            end
         end
         S_CLK_HI: begin
            // data_out is left untouched here so DS is stable a full tick around the SH_CP rise.
            if (wr_en) begin
               register_clock_nxt = 1'b1;
               if (cnt == '0) begin
                  state_nxt = S_LATCH_HI;
               end else begin
                  cnt_nxt   = cnt - CW'(1);
                  sr_nxt    = MSB_FIRST ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};
                  state_nxt = S_SETUP;
               end
            end
         end
         S_LATCH_HI: begin
            if (wr_en) begin
               register_clock_nxt = 1'b0;
               latch_nxt          = 1'b1;
               state_nxt          = S_LATCH_LO;
            end
         end
         S_LATCH_LO: begin
            if (wr_en) begin
               latch_nxt = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         sr             <= '0;
         cnt            <= '0;
         hold_dat       <= '0;
         hold_vld       <= 1'b0;
         data_out       <= 1'b0;
         register_clock <= 1'b0;
         latch          <= 1'b0;
         done           <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         state          <= state_nxt;
         sr             <= sr_nxt;
         cnt            <= cnt_nxt;
         hold_dat       <= hold_dat_nxt;
         hold_vld       <= hold_vld_nxt;
         data_out       <= data_out_nxt;
         register_clock <= register_clock_nxt;
         latch          <= latch_nxt;
         done           <= done_nxt;
         overrun        <= overrun_nxt;
      end
   end

   assign ready = !hold_vld;
   assign busy  = (state != S_IDLE);

endmodule

// File: doc/shift_74hc595_chain.md
# shift_74hc595_chain

Parametrised driver for a daisy-chain of CHIPS 74HC595 shift registers, the successor to the single-chip `shift_74hc595`. It accepts a CHIPS×8-bit frame through a one-deep holding buffer and serialises it onto DS/SH_CP/ST_CP, paced by an external clock-enable strobe (`binary_divider_clock_enable` output). It supports configurable bit order and last-write-wins frame coalescing, and reports busy/done/overrun status. It sits between a frame producer (UART receiver, pattern generator) and the board pins.

## Interface
- CHIPS, 1, number of chained 74HC595s; frame width W = 8*CHIPS (CHIPS ≥ 1)
- MSB_FIRST, 1, 1: data_in[W-1] shifted first (ends in last chip's QH); 0: data_in[0] first
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- rd_en  in  1  one-cycle strobe: capture data_in into holding buffer
- data_in  in  W  frame to display
- wr_en  in  1  bit-rate clock-enable tick; state advances only on cycles with wr_en=1 (except IDLE load)
- ready  out  1  holding buffer empty
- busy  out  1  frame being serialised (state ≠ IDLE)
- done  out  1  one-cycle pulse when a frame has been latched
- overrun  out  1  one-cycle pulse when rd_en overwrote an unconsumed buffered frame
- data_out  out  1  serial data to DS of first chip
- register_clock  out  1  SH_CP
- latch  out  1  ST_CP

## Operation
- Holding buffer: buf (W bits) + buf_valid. rd_en=1 → buf←data_in, buf_valid←1. If buf_valid was already 1 and not consumed that cycle, overrun pulses 1 cycle later; new data replaces old (last write wins). ready = !buf_valid.
- Shift register sr (W bits), bit counter cnt (clog2(W) bits, min 1).
- States:
  - IDLE: if buf_valid → sr←buf, buf_valid←0, cnt←W-1, go SETUP (no tick required). rd_en in same cycle as consume: buffer reloads, buf_valid stays 1, no overrun.
  - SETUP (on tick): data_out←next bit (sr MSB if MSB_FIRST else LSB), register_clock←0 → CLK_HI.
  - CLK_HI (on tick): register_clock←1; if cnt==0 → LATCH_HI, else cnt←cnt-1, shift sr toward the output end → SETUP.
  - LATCH_HI (on tick): register_clock←0, latch←1 → LATCH_LO.
  - LATCH_LO (on tick): latch←0, done←1 for one cycle → IDLE.
- data_out holds its value through CLK_HI (setup/hold guaranteed by one tick on each side of the SH_CP rising edge).
- rd_en during busy never disturbs the frame in flight; it only fills/overwrites buf.
- Reset (any state, including mid-frame): state←IDLE, buf_valid←0, sr←0, cnt←0; partial frame abandoned, latch never pulsed for it.

## Timing
- Reset values: data_out=0, register_clock=0, latch=0, busy=0, ready=1, done=0, overrun=0.
- rd_en at cycle t → ready=0 at t+1; if IDLE, busy=1 and ready=1 at t+2.
- Frame duration: 2W+2 wr_en ticks after leaving IDLE; done asserted the cycle after the LATCH_LO tick.
- Back-to-back: with buf_valid set, next frame starts the cycle after done (IDLE dwell exactly 1 cycle).
- wr_en held constantly high: W=8 frame completes in 18 cycles + 1 load cycle.
- All outputs registered; no combinational path from inputs to pins.

## Test plan
- CHIPS=2, MSB_FIRST=1, wr_en every 4th cycle, rd_en with data_in=16'hA5C3 → 16 SH_CP rising edges, DS sampled at each edge = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; one latch pulse after the 16th edge; done once; 595 model outputs 16'hA5C3.
- MSB_FIRST=0, CHIPS=1, data_in=8'h01 → DS=1 on first edge only, then 0×7; model output 8'h01.
- Two rd_en while busy (16'h1111 then 16'h2222) → overrun pulses once; next displayed frame 16'h2222; 16'h1111 never latched.
- rd_en same cycle as IDLE consume → no overrun, both frames displayed in order, IDLE dwell 1 cycle between done and next SETUP.
- rst_n low mid-frame (after 5 edges) → next cycle all outputs at reset values, no latch pulse, ready=1; new frame afterwards displays correctly.
- wr_en tied low after rd_en → busy=1, pins frozen, no SH_CP edge; resume wr_en → frame completes in 2W+2 ticks.
